// File: rtl/cpu_controller.sv
// Moore control FSM for a small register-file/ALU datapath.
// Holds the instruction register and sequences operand fetch, ALU and writeback.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StGetA,
        StGetB,
        StAlu,
        StWriteReg,
        StWriteImm
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWait;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            // IR only accepts a new word while idle, so a running instruction is stable.
            if (load && (state_q == StWait)) begin
                ir_q <= in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StWait:     if (s) state_d = StDecode;
            StDecode: begin
                if (is_mov_imm)               state_d = StWriteImm;
                else if (is_mov_reg || is_mvn) state_d = StGetB;
                else if (is_alu)              state_d = StGetA;
                else                          state_d = StWait;
            end
            StGetA:     state_d = StGetB;
            StGetB:     state_d = StAlu;
            StAlu:      state_d = is_cmp ? StWait : StWriteReg;
            StWriteReg: state_d = StWait;
            StWriteImm: state_d = StWait;
            default:    state_d = StWait;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        vsel     = 4'b0000;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state_q)
            StWait: w = 1'b1;
            StGetA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            StGetB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            StAlu: begin
                // Single-operand ops zero the A input so the ALU passes/inverts B.
                asel  = is_mov_reg || is_mvn;
                loadc = 1'b1;
                loads = is_cmp;
                shift = sh;
                ALUop = is_mov_reg ? 2'b00 : op;
            end
            StWriteReg: begin
                vsel     = 4'b1000;
                writenum = rd;
                write    = 1'b1;
            end
            StWriteImm: begin
                vsel     = 4'b0010;
                writenum = rn;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
